// File: rtl/mix_column_engine_if.sv
// Block handshake bus for mix_column_engine: input channel, output channel and busy status.
interface mix_column_engine_if;
    localparam int unsigned DATA_W = 128;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic              inv;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              busy;

    modport master (
        output in_valid, data_in, inv, out_ready,
        input  in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, data_in, inv, out_ready,
        output in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/mix_column_engine.sv
// Iterative AES MixColumns engine, COLS_PER_CYCLE columns per beat.
// Define MIX_COLUMN_INV_EN to build the InvMixColumns datapath selected per block by inv.
module mix_column_engine #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    mix_column_engine_if.slave  bus
);
    localparam int unsigned NBEATS = 4 / COLS_PER_CYCLE;
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned COL_W  = 32;
    localparam int unsigned DATA_W = 128;

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $error("mix_column_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [DATA_W-1:0]  src, src_n;
    logic [DATA_W-1:0]  res, res_n;
    logic [DATA_W-1:0]  data_out_q, data_out_n;
    logic               in_ready_q, out_valid_q, busy_q;
    logic [6:0]         col_base;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_fwd(input logic [31:0] c);
        logic [7:0] s0, s1, s2, s3, d0, d1, d2, d3;
        s0 = c[7:0];   s1 = c[15:8];  s2 = c[23:16]; s3 = c[31:24];
        d0 = xtime(s0); d1 = xtime(s1); d2 = xtime(s2); d3 = xtime(s3);
        // 3*s is formed as xtime(s) ^ s
        return {d0 ^ s0 ^ s1 ^ s2 ^ d3,
                s0 ^ s1 ^ d2 ^ d3 ^ s3,
                s0 ^ d1 ^ d2 ^ s2 ^ s3,
                d0 ^ d1 ^ s1 ^ s2 ^ s3};
    endfunction

`ifdef MIX_COLUMN_INV_EN
    logic mode, mode_n;

    function automatic logic [31:0] mix_inv(input logic [31:0] c);
        logic [7:0] s [4];
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            s[i]   = c[8*i +: 8];
            x2     = xtime(s[i]);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m9[i]  = x8 ^ s[i];
            m11[i] = x8 ^ x2 ^ s[i];
            m13[i] = x8 ^ x4 ^ s[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m11[0] ^ m13[1] ^ m9[2]  ^ m14[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m14[0] ^ m11[1] ^ m13[2] ^ m9[3]};
    endfunction
`else
    logic unused_inv;
    assign unused_inv = bus.inv;
`endif

    // Next-state, beat datapath and output staging
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        src_n      = src;
        res_n      = res;
        data_out_n = data_out_q;
        col_base   = '0;
`ifdef MIX_COLUMN_INV_EN
        mode_n     = mode;
`endif
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    src_n   = bus.data_in;
                    cnt_n   = '0;
                    state_n = BUSY;
`ifdef MIX_COLUMN_INV_EN
                    mode_n  = bus.inv;
`endif
                end
            end
            BUSY: begin
                for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
                    col_base = 7'((32'(cnt) * COLS_PER_CYCLE + k) * COL_W);
`ifdef MIX_COLUMN_INV_EN
                    res_n[col_base +: COL_W] = mode ? mix_inv(src[col_base +: COL_W])
                                                    : mix_fwd(src[col_base +: COL_W]);
`else
                    res_n[col_base +: COL_W] = mix_fwd(src[col_base +: COL_W]);
`endif
                end
                if (cnt == CNT_W'(NBEATS - 1)) begin
                    cnt_n      = '0;
                    data_out_n = res_n;
                    state_n    = DONE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register; handshake flags are decoded from the next state so they stay registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            src         <= '0;
            res         <= '0;
            data_out_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MIX_COLUMN_INV_EN
            mode        <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            src         <= src_n;
            res         <= res_n;
            data_out_q  <= data_out_n;
            in_ready_q  <= (state_n == IDLE);
            out_valid_q <= (state_n == DONE);
            busy_q      <= (state_n != IDLE);
`ifdef MIX_COLUMN_INV_EN
            mode        <= mode_n;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mix_column_engine.sv
// Self-checking bench for mix_column_engine against a GF(2^8) matrix-product model.
`timescale 1ns/1ps
module tb_mix_column_engine #(
    parameter int unsigned COLS_PER_CYCLE = 1
);
    localparam int unsigned NBEATS = 4 / COLS_PER_CYCLE;
`ifdef MIX_COLUMN_INV_EN
    localparam bit INV_BUILT = 1'b1;
`else
    localparam bit INV_BUILT = 1'b0;
`endif

    localparam logic [127:0] V_IN  = {32'h01010101, 32'h5c220af2, 32'h455313db, 32'hd5d4d4d4};
    localparam logic [127:0] V_OUT = {32'h01010101, 32'h9d58dc9f, 32'hbca14d8e, 32'hd6d7d5d5};
    localparam logic [127:0] V_C6  = {4{32'hc6c6c6c6}};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mix_column_engine_if bus();

    mix_column_engine #(.COLS_PER_CYCLE(COLS_PER_CYCLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    // Generic shift-and-add multiply in GF(2^8) mod 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant first row of the (inverse) MixColumns matrix
    function automatic logic [7:0] coef(input logic use_inv, input int k);
        logic [7:0] r;
        case (k)
            0:       r = use_inv ? 8'd14 : 8'd2;
            1:       r = use_inv ? 8'd11 : 8'd3;
            2:       r = use_inv ? 8'd13 : 8'd1;
            default: r = use_inv ? 8'd9  : 8'd1;
        endcase
        return r;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv_m);
        logic [127:0] o = '0;
        logic [7:0]   acc;
        logic         use_inv = inv_m & INV_BUILT;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(coef(use_inv, (j - r + 4) % 4), d[32*c + 8*j +: 8]);
                o[32*c + 8*r +: 8] = acc;
            end
        end
        return o;
    endfunction

    logic [127:0] exp_q [$];
    int           acc_q [$];
    int           cyc       = 0;
    int           out_cnt   = 0;
    int           last_rise = -1;
    bit           prev_ov   = 1'b0;
    bit           b2b       = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle comparison against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            acc_q.delete();
            prev_ov = 1'b0;
        end else begin
            check("ready_vs_busy", 128'(bus.in_ready), 128'(!bus.busy));
            if (bus.out_valid) begin
                check("ready_low_in_done", 128'(bus.in_ready), 128'(0));
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 128'(bus.out_valid), 128'(0));
                end else begin
                    check("data_out", bus.data_out, exp_q[0]);
                    if (!prev_ov) begin
                        check("latency", 128'(cyc - acc_q[0]), 128'(NBEATS));
                        if (b2b && last_rise >= 0)
                            check("interval", 128'(cyc - last_rise), 128'(NBEATS + 2));
                        last_rise = cyc;
                    end
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        void'(acc_q.pop_front());
                        out_cnt++;
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.data_in, bus.inv));
                acc_q.push_back(cyc + 1);
            end
            prev_ov = bus.out_valid;
        end
    end

    task automatic send(input logic [127:0] d, input logic iv, input bit hold);
        bit ok = 1'b0;
        bus.data_in  = d;
        bus.inv      = iv;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 128'(ok), 128'(1));
        @(posedge clk);
        #1;
        if (!hold) bus.in_valid = 1'b0;
        bus.data_in = {$urandom, $urandom, $urandom, $urandom};
        bus.inv     = ~iv;
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("out_valid_timeout", 128'(ok), 128'(1));
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 128'(ok), 128'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int           base;
        logic [127:0] blk;
        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.inv       = 1'b0;
        bus.out_ready = 1'b0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  128'(bus.in_ready),  128'(1));
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_data_out",  bus.data_out,        128'(0));
        check("rst_busy",      128'(bus.busy),      128'(0));

        // Pin the model with hand-computed vectors
        check("model_fwd", model(V_IN, 1'b0), V_OUT);
        check("model_c6",  model(V_C6, 1'b0), V_C6);
`ifdef MIX_COLUMN_INV_EN
        check("model_inv", model(V_OUT, 1'b1), V_IN);
`else
        check("model_inv_off", model(V_IN, 1'b1), V_OUT);
`endif

        // Forward vector
        bus.out_ready = 1'b1;
        send(V_IN, 1'b0, 1'b0);
        wait_valid();
        check("fwd_vector", bus.data_out, V_OUT);
        drain();

        // Inverse vector, or inv ignored without the inverse datapath
`ifdef MIX_COLUMN_INV_EN
        send(V_OUT, 1'b1, 1'b0);
        wait_valid();
        check("inv_vector", bus.data_out, V_IN);
`else
        send(V_IN, 1'b1, 1'b0);
        wait_valid();
        check("inv_ignored", bus.data_out, V_OUT);
`endif
        drain();

        // Output stall with a rejected input pulse
        base          = out_cnt;
        bus.out_ready = 1'b0;
        blk           = {$urandom, $urandom, $urandom, $urandom};
        send(blk, 1'b0, 1'b0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1'b1;
                bus.data_in  = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            check("stall_out_valid", 128'(bus.out_valid), 128'(1));
            check("stall_in_ready",  128'(bus.in_ready),  128'(0));
            check("stall_data",      bus.data_out,        model(blk, 1'b0));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        drain();
        send({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        drain();
        check("stall_out_count", 128'(out_cnt - base), 128'(2));

        // Back-to-back stream with in_valid held high
        base      = out_cnt;
        last_rise = -1;
        b2b       = 1'b1;
        for (int i = 0; i < 8; i++)
            send({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(1)), 1'b1);
        bus.in_valid = 1'b0;
        drain();
        b2b = 1'b0;
        check("b2b_out_count", 128'(out_cnt - base), 128'(8));

        // Reset during BUSY
        base = out_cnt;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
        if (NBEATS > 1) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        check("midrst_in_ready",  128'(bus.in_ready),  128'(1));
        check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
        check("midrst_data_out",  bus.data_out,        128'(0));
        check("midrst_busy",      128'(bus.busy),      128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_output", 128'(out_cnt - base), 128'(0));
        send(V_C6, 1'b0, 1'b0);
        wait_valid();
        check("c6_vector", bus.data_out, V_C6);
        drain();

        check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
